// File: rtl/ifu_if.sv
// Fetch-unit bundle: instruction-memory request/response, redirect input and
// the decode-side output register. The master side is the fetch unit.
interface ifu_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [1:0]  out_fault;

  modport master (
    output req_valid, req_addr, rsp_ready,
    output out_valid, out_inst, out_pc, out_fault,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    input  out_valid, out_inst, out_pc, out_fault,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory read at
// a time, holds the fetched word for decode and applies downstream redirects,
// discarding any response that belongs to a superseded fetch.
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master bus
);

  typedef enum logic [2:0] {
    BOOT,   // one idle cycle after reset
    REQ,    // presenting a fetch request
    WAIT,   // request accepted, waiting for its response
    HOLD,   // instruction held for decode
    DRAIN   // waiting for a stale response to retire
  } state_t;

  localparam logic [1:0] FAULT_NONE   = 2'b00;
  localparam logic [1:0] FAULT_ACCESS = 2'b01;
  localparam logic [1:0] FAULT_ALIGN  = 2'b10;

  state_t      state_reg;
  logic [63:0] pc_reg;
  logic [31:0] out_inst_reg;
  logic [63:0] out_pc_reg;
  logic [1:0]  out_fault_reg;
  logic        out_valid_reg;

  logic aligned;
  logic req_fire;

  // Requests go out only for word-aligned PCs; a misaligned PC faults locally.
  assign aligned       = (pc_reg[1:0] == 2'b00);
  assign bus.req_valid = (state_reg == REQ) && aligned;
  assign bus.req_addr  = pc_reg;
  assign bus.rsp_ready = (state_reg == WAIT) || (state_reg == DRAIN);
  assign req_fire      = bus.req_valid && bus.req_ready;

  assign bus.out_valid = out_valid_reg;
  assign bus.out_inst  = out_inst_reg;
  assign bus.out_pc    = out_pc_reg;
  assign bus.out_fault = out_fault_reg;

  // Fetch FSM together with the PC and the decode-side output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= BOOT;
      pc_reg        <= RESET_PC;
      out_inst_reg  <= '0;
      out_pc_reg    <= RESET_PC;
      out_fault_reg <= FAULT_NONE;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          state_reg <= REQ;
        end

        REQ: begin
          if (bus.redirect_valid) begin
            // A request accepted this very cycle is still owed a response.
            pc_reg        <= bus.redirect_pc;
            out_valid_reg <= 1'b0;
            state_reg     <= req_fire ? DRAIN : REQ;
          end else if (!aligned) begin
            out_inst_reg  <= NOP_INST;
            out_pc_reg    <= pc_reg;
            out_fault_reg <= FAULT_ALIGN;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else if (req_fire) begin
            state_reg <= WAIT;
          end
        end

        WAIT: begin
          if (bus.redirect_valid) begin
            // A response in the same cycle is simply dropped; otherwise
            // the outstanding one must be drained first.
            pc_reg        <= bus.redirect_pc;
            out_valid_reg <= 1'b0;
            state_reg     <= bus.rsp_valid ? REQ : DRAIN;
          end else if (bus.rsp_valid) begin
            out_inst_reg  <= bus.rsp_err ? NOP_INST : bus.rsp_data;
            out_pc_reg    <= pc_reg;
            out_fault_reg <= bus.rsp_err ? FAULT_ACCESS : FAULT_NONE;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end
        end

        HOLD: begin
          if (bus.redirect_valid) begin
            // Held instruction is dropped and the PC is not advanced.
            pc_reg        <= bus.redirect_pc;
            out_valid_reg <= 1'b0;
            state_reg     <= REQ;
          end else if (bus.out_ready) begin
            pc_reg        <= pc_reg + 64'd4;
            out_valid_reg <= 1'b0;
            state_reg     <= REQ;
          end
        end

        DRAIN: begin
          if (bus.redirect_valid) begin
            pc_reg        <= bus.redirect_pc;
            out_valid_reg <= 1'b0;
          end
          if (bus.rsp_valid) begin
            state_reg <= REQ;
          end
        end

        default: begin
          state_reg <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for the fetch unit: a small instruction-memory model answers requests,
// the stimulus thread pushes expected requests and decode outputs into queues,
// and separate monitors pop and compare them as the handshakes happen.
module tb_ifu;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [1:0]  fault;
  } out_t;

  logic clk;
  logic rst;

  ifu_if bus ();

  ifu #(
    .RESET_PC(64'h8000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_req[$];
  out_t        exp_out[$];
  out_t        exp_e;
  logic [63:0] exp_a;

  // Memory-model controls
  int          rsp_delay;
  logic        force_en;
  logic [31:0] force_data;
  logic [63:0] err_addr;

  logic        pend;
  int          cnt;
  logic [31:0] pdata;
  logic        perr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written memory contents
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h8000_0000: return 32'h0000_0297;
      64'h8000_0004: return 32'h0000_0513;
      64'h8000_0100: return 32'h0010_0093;
      default:       return 32'h0000_0033;
    endcase
  endfunction

  // Instruction memory: answers each accepted request after rsp_delay extra cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend          <= 1'b0;
      cnt           <= 0;
      pdata         <= '0;
      perr          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= pdata;
          bus.rsp_err   <= perr;
          pend          <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        if (rsp_delay == 0) begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= force_en ? force_data : mem_word(bus.req_addr);
          bus.rsp_err   <= (bus.req_addr == err_addr);
        end else begin
          pend  <= 1'b1;
          cnt   <= rsp_delay - 1;
          pdata <= force_en ? force_data : mem_word(bus.req_addr);
          perr  <= (bus.req_addr == err_addr);
        end
      end
    end
  end

  // Request monitor
  always @(negedge clk) begin
    if (!rst && bus.req_valid && bus.req_ready) begin
      $display("[TB] req addr=%h", bus.req_addr);
      tests++;
      if (exp_req.size() == 0) begin
        fails++;
        $display("FAIL req_unexpected: got addr %h, required no request", bus.req_addr);
      end else begin
        exp_a = exp_req.pop_front();
        if (bus.req_addr !== exp_a) begin
          fails++;
          $display("FAIL req_addr: got %h, required %h", bus.req_addr, exp_a);
        end
      end
    end
  end

  // Decode-output monitor; a redirect in the same cycle drops the instruction
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      $display("[TB] out pc=%h inst=%h fault=%0d", bus.out_pc, bus.out_inst, bus.out_fault);
      tests++;
      if (exp_out.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got pc=%h inst=%h, required none", bus.out_pc, bus.out_inst);
      end else begin
        exp_e = exp_out.pop_front();
        if (bus.out_inst !== exp_e.inst || bus.out_pc !== exp_e.pc || bus.out_fault !== exp_e.fault) begin
          fails++;
          $display("FAIL out_data: got inst=%h pc=%h fault=%0d, required inst=%h pc=%h fault=%0d",
                   bus.out_inst, bus.out_pc, bus.out_fault, exp_e.inst, exp_e.pc, exp_e.fault);
        end
      end
    end
  end

  // Protocol check: the memory must never answer while the fetch unit is not ready
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(bus.rsp_valid && !bus.rsp_ready))
      else begin
        fails++;
        $display("FAIL rsp_protocol: got rsp_valid=1 with rsp_ready=0, required rsp_ready=1");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_out(input logic [31:0] inst, input logic [63:0] pc, input logic [1:0] fault);
    out_t e;
    e.inst  = inst;
    e.pc    = pc;
    e.fault = fault;
    exp_out.push_back(e);
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!bus.out_valid) begin
      fails++;
      $display("FAIL %s_timeout: got out_valid=0, required out_valid=1 within 40 cycles", name);
    end
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.req_valid && bus.req_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!(bus.req_valid && bus.req_ready)) begin
      fails++;
      $display("FAIL %s_timeout: got no request, required a request within 40 cycles", name);
    end
  endtask

  // Accept the currently held instruction for exactly one cycle
  task automatic accept_one();
    step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    bus.req_ready      = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    rsp_delay          = 0;
    force_en           = 1'b0;
    force_data         = '0;
    err_addr           = 64'h8000_0008;

    // Reset state
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0004);
    push_out(32'h0000_0297, 64'h8000_0000, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_req_valid", {63'd0, bus.req_valid}, 64'd0);
    check("rst_req_addr", bus.req_addr, 64'h8000_0000);
    check("rst_out_pc", bus.out_pc, 64'h8000_0000);
    check("rst_out_inst", {32'd0, bus.out_inst}, 64'd0);
    check("rst_out_fault", {62'd0, bus.out_fault}, 64'd0);
    step();
    rst = 1'b0;

    // First fetch latency: BOOT, request N, response N+1, out N+2, request N+3
    @(negedge clk);
    check("boot_no_req", {63'd0, bus.req_valid}, 64'd0);
    @(negedge clk);
    check("first_req_valid", {63'd0, bus.req_valid}, 64'd1);
    check("first_req_addr", bus.req_addr, 64'h8000_0000);
    @(negedge clk);
    check("rsp_cycle_out_valid", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    check("n2_out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("n2_out_inst", {32'd0, bus.out_inst}, 64'h0000_0297);
    check("n2_out_fault", {62'd0, bus.out_fault}, 64'd0);
    @(negedge clk);
    check("n3_req_valid", {63'd0, bus.req_valid}, 64'd1);
    check("n3_req_addr", bus.req_addr, 64'h8000_0004);
    step();
    bus.out_ready = 1'b0;

    // Backpressure: output holds, no new request
    push_out(32'h0000_0513, 64'h8000_0004, 2'b00);
    wait_out_valid("bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_out_inst", {32'd0, bus.out_inst}, 64'h0000_0513);
      check("bp_out_pc", bus.out_pc, 64'h8000_0004);
      check("bp_no_req", {63'd0, bus.req_valid}, 64'd0);
      if (i < 4) @(negedge clk);
    end
    exp_req.push_back(64'h8000_0008);
    push_out(32'h0000_0013, 64'h8000_0008, 2'b01);
    accept_one();

    // Access fault on 0x8000_0008
    wait_out_valid("err");
    check("err_out_fault", {62'd0, bus.out_fault}, 64'd1);
    check("err_out_inst", {32'd0, bus.out_inst}, 64'h0000_0013);

    // Redirect in WAIT; stale 0xDEADBEEF response drained two cycles later
    exp_req.push_back(64'h8000_000C);
    force_en   = 1'b1;
    force_data = 32'hDEAD_BEEF;
    rsp_delay  = 2;
    accept_one();
    wait_req("drain_req");
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0100;
    force_en           = 1'b0;
    rsp_delay          = 0;
    exp_req.push_back(64'h8000_0100);
    @(negedge clk);
    check("wait_redir_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("wait_redir_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("drain_rsp_ready", {63'd0, bus.rsp_ready}, 64'd1);
    check("drain_no_req", {63'd0, bus.req_valid}, 64'd0);
    @(negedge clk);
    check("drain_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    check("drain_rsp_ready2", {63'd0, bus.rsp_ready}, 64'd1);
    check("drain_out_valid", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    check("post_drain_req_valid", {63'd0, bus.req_valid}, 64'd1);
    check("post_drain_req_addr", bus.req_addr, 64'h8000_0100);
    check("post_drain_out_valid", {63'd0, bus.out_valid}, 64'd0);

    // Redirect together with out_ready in HOLD, to a misaligned target
    wait_out_valid("fetch_100");
    check("f100_out_inst", {32'd0, bus.out_inst}, 64'h0010_0093);
    check("f100_out_pc", bus.out_pc, 64'h8000_0100);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0202;
    bus.out_ready      = 1'b1;
    push_out(32'h0000_0013, 64'h8000_0202, 2'b10);
    @(negedge clk);
    step();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b0;
    @(negedge clk);
    check("mis_req_addr", bus.req_addr, 64'h8000_0202);
    check("mis_no_req", {63'd0, bus.req_valid}, 64'd0);
    check("mis_out_valid0", {63'd0, bus.out_valid}, 64'd0);
    wait_out_valid("mis");
    check("mis_out_fault", {62'd0, bus.out_fault}, 64'd2);
    check("mis_out_pc", bus.out_pc, 64'h8000_0202);
    check("mis_hold_no_req", {63'd0, bus.req_valid}, 64'd0);
    accept_one();
    wait_out_valid("mis_next");
    check("mis_next_pc", bus.out_pc, 64'h8000_0206);
    check("mis_next_fault", {62'd0, bus.out_fault}, 64'd2);

    // Redirect out of HOLD, then redirect coinciding with a response in WAIT
    exp_req.push_back(64'h8000_0300);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0300;
    step();
    bus.redirect_valid = 1'b0;
    wait_req("req_300");
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0400;
    rsp_delay          = 3;
    exp_req.push_back(64'h8000_0400);
    @(negedge clk);
    check("wr_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("wr_req_valid", {63'd0, bus.req_valid}, 64'd1);
    check("wr_req_addr", bus.req_addr, 64'h8000_0400);
    check("wr_no_drain", {63'd0, bus.rsp_ready}, 64'd0);
    check("wr_out_valid", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    check("slow_wait_rsp_ready", {63'd0, bus.rsp_ready}, 64'd1);

    // Asynchronous reset in the middle of WAIT
    step();
    rst = 1'b1;
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0004);
    push_out(32'h0000_0297, 64'h8000_0000, 2'b00);
    rsp_delay = 0;
    #1;
    check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("arst_req_valid", {63'd0, bus.req_valid}, 64'd0);
    check("arst_req_addr", bus.req_addr, 64'h8000_0000);
    check("arst_rsp_ready", {63'd0, bus.rsp_ready}, 64'd0);
    step();
    rst = 1'b0;
    wait_out_valid("restart");
    check("restart_out_pc", bus.out_pc, 64'h8000_0000);
    accept_one();
    wait_out_valid("restart_next");
    check("restart_next_pc", bus.out_pc, 64'h8000_0004);
    repeat (2) @(negedge clk);
    check("exp_req_left", 64'(exp_req.size()), 64'd0);
    check("exp_out_left", 64'(exp_out.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
